controlador_escritura_rtc: RTL and testbench

Write sequencer for the RTC's multiplexed 8-bit address/data bus. It starts when the start-write flag from the PicoBlaze port register is high. It then drives a complete two-phase write on the bus: an address phase followed by a data phase, each with setup, strobe and hold. At the end it pulses `listo`, and that pulse clears the start-write flag. The block sits between the PicoBlaze I/O registers (address, data, start) and the top-level tristate pads of the RTC bus. It performs writes only; reads belong to a separate block.

---
 rtl/controlador_escritura_rtc.sv | 152 +++++++++++++++
 tb/tb_controlador_escritura_rtc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_escritura_rtc.sv
// Write sequencer for the RTC multiplexed AD bus: address phase then data phase,
// each with setup / strobe / hold of T_FASE cycles, followed by a one-cycle listo.
module controlador_escritura_rtc #(
  parameter int T_FASE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arranque,
  input  logic [7:0] direccion,
  input  logic [7:0] dato,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ocupado,
  output logic       listo
);

  localparam int CW = $clog2(T_FASE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_FASE - 1);

  typedef enum logic [2:0] {
    IDLE, DIR_SETUP, DIR_WR, DIR_HOLD, DAT_SETUP, DAT_WR, DAT_HOLD, DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          armado, armado_next;
  logic          capture;
  logic [7:0]    dir_q, dat_q;
  logic [7:0]    addr_src;

  logic [7:0] ad_out_next;
  logic       ad_oe_next, cs_n_next, a_d_next, wr_n_next, ocupado_next, listo_next;

  // Request/complete handshake: arranque is a level request accepted in IDLE only
  // when armado is set (request seen low since the last write); listo pulses once
  // at completion and is expected to clear the request register.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    armado_next = armado;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (arranque && armado) begin
          capture     = 1'b1;
          armado_next = 1'b0;
          state_next  = DIR_SETUP;
        end else if (!arranque) begin
          armado_next = 1'b1;
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          case (state)
            DIR_SETUP: state_next = DIR_WR;
            DIR_WR:    state_next = DIR_HOLD;
            DIR_HOLD:  state_next = DAT_SETUP;
            DAT_SETUP: state_next = DAT_WR;
            DAT_WR:    state_next = DAT_HOLD;
            default:   state_next = DONE;
          endcase
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the bus follows
  // the state with no input-to-output path; the address is taken straight from
  // the input on the capture edge, when dir_q is being loaded at the same time.
  assign addr_src = capture ? direccion : dir_q;

  always_comb begin
    ad_out_next  = 8'h00;
    ad_oe_next   = 1'b0;
    cs_n_next    = 1'b1;
    a_d_next     = 1'b1;
    wr_n_next    = 1'b1;
    ocupado_next = 1'b0;
    listo_next   = 1'b0;
    case (state_next)
      DIR_SETUP, DIR_WR, DIR_HOLD: begin
        ad_out_next  = addr_src;
        ad_oe_next   = 1'b1;
        cs_n_next    = 1'b0;
        a_d_next     = 1'b0;
        wr_n_next    = (state_next != DIR_WR);
        ocupado_next = 1'b1;
      end
      DAT_SETUP, DAT_WR, DAT_HOLD: begin
        ad_out_next  = dat_q;
        ad_oe_next   = 1'b1;
        cs_n_next    = 1'b0;
        a_d_next     = 1'b1;
        wr_n_next    = (state_next != DAT_WR);
        ocupado_next = 1'b1;
      end
      DONE: begin
        ocupado_next = 1'b1;
        listo_next   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      armado  <= 1'b1;
      dir_q   <= 8'h00;
      dat_q   <= 8'h00;
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      a_d     <= 1'b1;
      wr_n    <= 1'b1;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      armado  <= armado_next;
      if (capture) begin
        dir_q <= direccion;
        dat_q <= dato;
      end
      ad_out  <= ad_out_next;
      ad_oe   <= ad_oe_next;
      cs_n    <= cs_n_next;
      a_d     <= a_d_next;
      wr_n    <= wr_n_next;
      ocupado <= ocupado_next;
      listo   <= listo_next;
    end
  end

  // Write-only block: the read strobe is permanently inactive.
  assign rd_n = 1'b1;

endmodule

// File: tb/tb_controlador_escritura_rtc.sv
// Bench: two sequencers (T_FASE=5 and T_FASE=1) driven by a start-register model,
// checked every cycle against a timeline model of the bus write.
module tb_controlador_escritura_rtc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arranque[2];
  logic [7:0] direccion[2];
  logic [7:0] dato[2];
  logic [7:0] ad_out[2];
  logic       ad_oe[2], cs_n[2], a_d[2], wr_n[2], rd_n[2], ocupado[2], listo[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    controlador_escritura_rtc #(.T_FASE(g == 0 ? 5 : 1)) dut (
      .clk(clk), .rst(rst), .arranque(arranque[g]),
      .direccion(direccion[g]), .dato(dato[g]),
      .ad_out(ad_out[g]), .ad_oe(ad_oe[g]), .cs_n(cs_n[g]), .a_d(a_d[g]),
      .wr_n(wr_n[g]), .rd_n(rd_n[g]), .ocupado(ocupado[g]), .listo(listo[g])
    );
  end

  function automatic int tf(int i);
    return (i == 0) ? 5 : 1;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one write = timeline of 6*T+1 cycles
  bit         m_busy[2];
  int         m_t[2];
  bit         m_armed[2];
  logic [7:0] m_addr[2], m_dat[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_t[i]     <= 0;
        m_armed[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (m_t[i] == 6 * tf(i)) m_busy[i] <= 1'b0;
          else m_t[i] <= m_t[i] + 1;
        end else if (arranque[i]) begin
          if (m_armed[i]) begin
            m_busy[i]  <= 1'b1;
            m_t[i]     <= 0;
            m_addr[i]  <= direccion[i];
            m_dat[i]   <= dato[i];
            m_armed[i] <= 1'b0;
          end
        end else begin
          m_armed[i] <= 1'b1;
        end
      end
    end
  end

  // {ad_out, ad_oe, cs_n, a_d, wr_n, rd_n, ocupado, listo}
  function automatic logic [14:0] expect_out(bit busy, int t, int f, logic [7:0] a, logic [7:0] d);
    if (!busy)       return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    if (t < 3 * f)   return {a, 1'b1, 1'b0, 1'b0, !(t >= f && t < 2 * f), 1'b1, 1'b1, 1'b0};
    if (t < 6 * f)   return {d, 1'b1, 1'b0, 1'b1, !(t >= 4 * f && t < 5 * f), 1'b1, 1'b1, 1'b0};
    return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  endfunction

  // ---------------- compare process
  int         escenario = 0;
  int         cyc = 0;
  int         prev_esc = 0;
  bit         prev_ocup[2], prev_wr[2], cap_valid[2];
  int         cap_cyc[2], low_run[2];
  int         hold_caps = 0;
  logic [7:0] last_addr[2], last_dat[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_ocup[i] = 1'b0; prev_wr[i] = 1'b1; cap_valid[i] = 1'b0;
      cap_cyc[i] = 0; low_run[i] = 0; last_addr[i] = 8'h00; last_dat[i] = 8'h00;
    end
    forever begin
      @(negedge clk or posedge rst);
      #1;
      for (int i = 0; i < 2; i++)
        check("bus", i, {ad_out[i], ad_oe[i], cs_n[i], a_d[i], wr_n[i], rd_n[i], ocupado[i], listo[i]},
              expect_out(m_busy[i], m_t[i], tf(i), m_addr[i], m_dat[i]));
      if (clk && rst) begin
        // asynchronous reset mid-cycle: bus released immediately
        check("rst_imm", 0, {cs_n[0], wr_n[0], ad_oe[0], listo[0], ocupado[0]}, 5'b11000);
        for (int i = 0; i < 2; i++) begin
          prev_ocup[i] = 1'b0; prev_wr[i] = 1'b1; low_run[i] = 0; cap_valid[i] = 1'b0;
        end
      end else if (!clk) begin
        cyc++;
        if (escenario == 3 && prev_esc != 3) hold_caps = 0;
        for (int i = 0; i < 2; i++) begin
          if (ocupado[i] && !prev_ocup[i]) begin
            if (i == 1 && cap_valid[i]) check("period_min", i, (cyc - cap_cyc[i]) >= 8, 1);
            cap_cyc[i] = cyc;
            cap_valid[i] = 1'b1;
            if (i == 0 && escenario == 3) hold_caps++;
          end
          if (!wr_n[i]) low_run[i]++;
          else if (!prev_wr[i]) begin
            check("wr_low_len", i, low_run[i], (i == 0) ? 5 : 1);
            low_run[i] = 0;
          end
          if (!cs_n[i] && !a_d[i]) last_addr[i] = ad_out[i];
          if (!cs_n[i] && a_d[i])  last_dat[i]  = ad_out[i];
          if (listo[i] && cap_valid[i]) begin
            check("listo_lat", i, cyc - cap_cyc[i], (i == 0) ? 30 : 6);
            if (i == 0 && escenario == 1) check("bus_values", i, {last_addr[i], last_dat[i]}, 16'h2159);
          end
          prev_ocup[i] = ocupado[i];
          prev_wr[i]   = wr_n[i];
        end
        if (prev_esc == 3 && escenario != 3) check("held_once", 0, hold_caps, 1);
        prev_esc = escenario;
      end
    end
  end

  // ---------------- stimulus: start-register model and drivers
  bit start_reg[2], hold[2], rnd[2], b2b[2];
  int low_cnt[2];

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (start_reg[i]) low_cnt[i] = 0;
      else low_cnt[i]++;
      if (listo[i] && !hold[i]) begin
        start_reg[i] = 1'b0;
        low_cnt[i] = 0;
      end
      if (rnd[i]) begin
        if ($urandom_range(0, 3) == 0) direccion[i] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) dato[i] = 8'($urandom);
        if (!start_reg[i] && low_cnt[i] >= 2 && $urandom_range(0, 5) == 0) start_reg[i] = 1'b1;
      end
      if (b2b[i] && !start_reg[i] && low_cnt[i] >= 2) start_reg[i] = 1'b1;
      arranque[i] = start_reg[i] | hold[i];
    end
  endtask

  task automatic wait_ready0(string name);
    int n = 0;
    while (!(m_busy[0] == 1'b0 && !start_reg[0] && low_cnt[0] >= 2) && n < 200) begin
      tick(); n++;
    end
    check(name, 0, n < 200, 1);
  endtask

  task automatic wait_listo0(string name);
    int n = 0;
    while (!listo[0] && n < 200) begin
      tick(); n++;
    end
    check(name, 0, n < 200, 1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_reg[i] = 1'b0; hold[i] = 1'b0; rnd[i] = 1'b0; b2b[i] = 1'b0;
      low_cnt[i] = 2; arranque[i] = 1'b0; direccion[i] = 8'h00; dato[i] = 8'h00;
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // single write 0x21/0x59, inputs disturbed three cycles after capture
    wait_ready0("tmo_ready1");
    escenario = 1;
    direccion[0] = 8'h21; dato[0] = 8'h59; start_reg[0] = 1'b1;
    tick();
    repeat (3) tick();
    direccion[0] = 8'h10; dato[0] = 8'hFF;
    wait_listo0("tmo_listo1");
    repeat (3) tick();
    escenario = 0;

    // start held high with the clear disconnected: only one write
    wait_ready0("tmo_ready3");
    escenario = 3;
    hold[0] = 1'b1;
    repeat (75) tick();
    hold[0] = 1'b0;
    escenario = 4;
    repeat (3) tick();
    direccion[0] = 8'hA5; dato[0] = 8'h3C; start_reg[0] = 1'b1;
    wait_listo0("tmo_listo4");
    escenario = 0;

    // reset while the data strobe is low, then a fresh write
    wait_ready0("tmo_ready5");
    escenario = 5;
    direccion[0] = 8'h7E; dato[0] = 8'h81; start_reg[0] = 1'b1;
    begin
      int n = 0;
      while (!(!wr_n[0] && a_d[0]) && n < 200) begin
        tick(); n++;
      end
      check("tmo_datwr", 0, n < 200, 1);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_listo0("tmo_listo5");
    escenario = 0;

    // T_FASE=1 back-to-back requests
    b2b[1] = 1'b1;
    repeat (60) tick();
    b2b[1] = 1'b0;

    // random traffic on both instances
    rnd[0] = 1'b1; rnd[1] = 1'b1;
    repeat (1500) tick();
    rnd[0] = 1'b0; rnd[1] = 1'b0;
    repeat (50) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
